// File: rtl/gp_reg_file.sv
// -----------------------------------------------------------------------------
// gp_reg_file
//   General-purpose register file: DEPTH registers of WIDTH bits, one write
//   port with load/increment/decrement/clear, and two independently enabled
//   read ports with one cycle of latency.
//   All outputs come from flops, so no input reaches an output combinationally.
//
// Ports
//   rf_clk        clock; all state updates on the rising edge
//   rf_rst        asynchronous reset, active-high; clears registers and outputs
//   rf_wr_en      write-port enable
//   rf_wr_op      00 load rf_wr_in, 01 increment, 10 decrement, 11 clear
//   rf_wr_addr    write-port register select
//   rf_wr_in      load data; used only when rf_wr_op is load
//   rf_rd_en_a/b  read-port enables
//   rf_rd_addr_a/b read-port register selects
//   rf_out_a/b    registered read data; holds its value while the port is idle
//   rf_valid_a/b  1 for the cycle after an enabled read, else 0
//   rf_wrap       1 for the cycle after an increment from all-ones or a
//                 decrement from zero
//
// Read-port protocol: there is no back-pressure. A read is issued by holding
// rf_rd_en_x high across a rising edge; on the following cycle rf_valid_x is 1
// and rf_out_x carries the data. rf_valid_x is a single-cycle qualifier, not a
// held flag, and rf_out_x is left unchanged by cycles with rf_rd_en_x low.
// -----------------------------------------------------------------------------
module gp_reg_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              rf_clk,
  input  logic              rf_rst,
  input  logic              rf_wr_en,
  input  logic [1:0]        rf_wr_op,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic [WIDTH-1:0]  rf_wr_in,
  input  logic              rf_rd_en_a,
  input  logic [ADDR_W-1:0] rf_rd_addr_a,
  input  logic              rf_rd_en_b,
  input  logic [ADDR_W-1:0] rf_rd_addr_b,
  output logic [WIDTH-1:0]  rf_out_a,
  output logic [WIDTH-1:0]  rf_out_b,
  output logic              rf_valid_a,
  output logic              rf_valid_b,
  output logic              rf_wrap
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_X = DEPTH[ADDR_W:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [DEPTH];

  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_result;
  logic             wr_hit;
  logic             wr_wrap;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_X);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Value a read port would capture this edge. Out-of-range and hard-wired
  // zero addresses read 0. With BYPASS the post-op value of a same-cycle
  // write is forwarded; wr_hit already excludes discarded writes, so the
  // zero register and out-of-range addresses never take the bypass.
  function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if (in_range(addr) && !is_zero_reg(addr)) begin
      if (BYPASS && wr_hit && (addr == rf_wr_addr)) val = wr_result;
      else                                          val = regs[addr];
    end
    return val;
  endfunction

  // Write-port datapath: operand fetch, op result, and wrap detection.
  always_comb begin
    wr_old    = '0;
    wr_result = '0;
    if (in_range(rf_wr_addr)) wr_old = regs[rf_wr_addr];
    case (rf_wr_op)
      OP_LOAD: wr_result = rf_wr_in;
      OP_INC:  wr_result = wr_old + ONE;
      OP_DEC:  wr_result = wr_old - ONE;
      OP_CLR:  wr_result = '0;
      default: wr_result = '0;
    endcase
    wr_hit  = rf_wr_en && in_range(rf_wr_addr) && !is_zero_reg(rf_wr_addr);
    wr_wrap = wr_hit && (((rf_wr_op == OP_INC) && (&wr_old)) ||
                         ((rf_wr_op == OP_DEC) && (wr_old == '0)));
  end

  always_comb begin
    rd_next_a = read_sel(rf_rd_addr_a);
    rd_next_b = read_sel(rf_rd_addr_b);
  end

  // Register storage.
  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[rf_wr_addr] <= wr_result;
    end
  end

  // Output registers.
  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      rf_out_a   <= '0;
      rf_out_b   <= '0;
      rf_valid_a <= 1'b0;
      rf_valid_b <= 1'b0;
      rf_wrap    <= 1'b0;
    end else begin
      rf_valid_a <= rf_rd_en_a;
      rf_valid_b <= rf_rd_en_b;
      rf_wrap    <= wr_wrap;
      if (rf_rd_en_a) rf_out_a <= rd_next_a;
      if (rf_rd_en_b) rf_out_b <= rd_next_b;
    end
  end

endmodule

// File: tb/tb_gp_reg_file.sv
// -----------------------------------------------------------------------------
// tb_gp_reg_file
//   Directed bench for gp_reg_file. Three instances share one stimulus:
//     u_dut : defaults (DEPTH 8, BYPASS 1, ZERO_REG 0)
//     u_dz  : BYPASS 0, ZERO_REG 1
//     u_d6  : DEPTH 6, so addresses 6 and 7 are out of range
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_gp_reg_file;

  localparam int W  = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [1:0]    wr_op = 2'b00;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_in = '0;
  logic          rd_en_a = 1'b0;
  logic [AW-1:0] rd_addr_a = '0;
  logic          rd_en_b = 1'b0;
  logic [AW-1:0] rd_addr_b = '0;

  logic [W-1:0] oa1, ob1, oaz, obz, oa6, ob6;
  logic         va1, vb1, vaz, vbz, va6, vb6;
  logic         wrap1, wrapz, wrap6;

  gp_reg_file u_dut (
    .rf_clk(clk), .rf_rst(rst), .rf_wr_en(wr_en), .rf_wr_op(wr_op),
    .rf_wr_addr(wr_addr), .rf_wr_in(wr_in),
    .rf_rd_en_a(rd_en_a), .rf_rd_addr_a(rd_addr_a),
    .rf_rd_en_b(rd_en_b), .rf_rd_addr_b(rd_addr_b),
    .rf_out_a(oa1), .rf_out_b(ob1), .rf_valid_a(va1), .rf_valid_b(vb1),
    .rf_wrap(wrap1)
  );

  gp_reg_file #(.BYPASS(1'b0), .ZERO_REG(1'b1)) u_dz (
    .rf_clk(clk), .rf_rst(rst), .rf_wr_en(wr_en), .rf_wr_op(wr_op),
    .rf_wr_addr(wr_addr), .rf_wr_in(wr_in),
    .rf_rd_en_a(rd_en_a), .rf_rd_addr_a(rd_addr_a),
    .rf_rd_en_b(rd_en_b), .rf_rd_addr_b(rd_addr_b),
    .rf_out_a(oaz), .rf_out_b(obz), .rf_valid_a(vaz), .rf_valid_b(vbz),
    .rf_wrap(wrapz)
  );

  gp_reg_file #(.DEPTH(6)) u_d6 (
    .rf_clk(clk), .rf_rst(rst), .rf_wr_en(wr_en), .rf_wr_op(wr_op),
    .rf_wr_addr(wr_addr), .rf_wr_in(wr_in),
    .rf_rd_en_a(rd_en_a), .rf_rd_addr_a(rd_addr_a),
    .rf_rd_en_b(rd_en_b), .rf_rd_addr_b(rd_addr_b),
    .rf_out_a(oa6), .rf_out_b(ob6), .rf_valid_a(va6), .rf_valid_b(vb6),
    .rf_wrap(wrap6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the next queued expectation and compares it.
  task automatic check_q(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected queue empty, got %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of stimulus, then returns 1 ns after the rising edge
  // so outputs can be sampled away from the edge.
  task automatic cyc(input logic we, input logic [1:0] op, input logic [AW-1:0] wa,
                     input logic [W-1:0] wd, input logic rea, input logic [AW-1:0] ra,
                     input logic reb, input logic [AW-1:0] rb);
    wr_en = we; wr_op = op; wr_addr = wa; wr_in = wd;
    rd_en_a = rea; rd_addr_a = ra; rd_en_b = reb; rd_addr_b = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", oa1, 16'h0000);
    check("rst_valid_a", {15'd0, va1}, 16'h0000);
    check("rst_wrap", {15'd0, wrap1}, 16'h0000);
    rst = 1'b0;

    // 1. Asynchronous reset mid-run.
    cyc(1'b1, LD, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd3);
    check("r3_pre_rst_a", oa1, 16'hBEEF);
    check("r3_pre_rst_b", ob1, 16'hBEEF);
    check("r3_pre_rst_va", {15'd0, va1}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_a", oa1, 16'h0000);
    check("async_rst_out_b", ob1, 16'h0000);
    check("async_rst_va", {15'd0, va1}, 16'h0000);
    check("async_rst_vb", {15'd0, vb1}, 16'h0000);
    #2 rst = 1'b0;
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 3'd0);
    check("r3_after_rst", oa1, 16'h0000);
    check("r3_after_rst_va", {15'd0, va1}, 16'h0001);

    // 2. Load then read, valid pulse, data hold.
    cyc(1'b1, LD, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 3'd0);
    check("r5_read", oa1, 16'h1234);
    check("r5_valid", {15'd0, va1}, 16'h0001);
    check("r5_valid_b_idle", {15'd0, vb1}, 16'h0000);
    idle();
    check("r5_hold", oa1, 16'h1234);
    check("r5_valid_drop", {15'd0, va1}, 16'h0000);

    // 3. Wrap on increment and decrement; load/clear never wrap.
    cyc(1'b1, LD, 3'd2, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    check("load_no_wrap", {15'd0, wrap1}, 16'h0000);
    cyc(1'b1, INC, 3'd2, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    check("inc_wrap", {15'd0, wrap1}, 16'h0001);
    check("inc_wrap_z", {15'd0, wrapz}, 16'h0001);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0);
    check("inc_wrap_pulse", {15'd0, wrap1}, 16'h0000);
    check("r2_after_inc", oa1, 16'h0000);
    cyc(1'b1, DEC, 3'd2, 16'h2222, 1'b0, 3'd0, 1'b0, 3'd0);
    check("dec_wrap", {15'd0, wrap1}, 16'h0001);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0);
    check("r2_after_dec", oa1, 16'hFFFF);
    check("dec_wrap_pulse", {15'd0, wrap1}, 16'h0000);
    cyc(1'b1, CLR, 3'd2, 16'h3333, 1'b0, 3'd0, 1'b0, 3'd0);
    check("clr_no_wrap", {15'd0, wrap1}, 16'h0000);
    cyc(1'b1, INC, 3'd2, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    check("inc_no_wrap", {15'd0, wrap1}, 16'h0000);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0);
    check("r2_clr_inc", oa1, 16'h0001);

    // 4. Same-cycle write and read of one register.
    cyc(1'b1, LD, 3'd1, 16'h0010, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b1, INC, 3'd1, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd0);
    check("bypass_on", oa1, 16'h0011);
    check("bypass_off", oaz, 16'h0010);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd0);
    check("r1_settled_z", oaz, 16'h0011);

    // 5. Dual read, including both ports on one register.
    cyc(1'b1, LD, 3'd4, 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b1, LD, 3'd6, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'hAAAA);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 3'd6);
    check_q("dual_a", oa1);
    check_q("dual_b", ob1);
    check("oob_read_d6", ob6, 16'h0000);
    check("oob_valid_d6", {15'd0, vb6}, 16'h0001);
    check("inrange_d6", oa6, 16'hAAAA);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 3'd4);
    check_q("same_a", oa1);
    check_q("same_b", ob1);
    cyc(1'b1, INC, 3'd7, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    check("oob_inc_no_wrap_d6", {15'd0, wrap6}, 16'h0000);

    // 6. Hard-wired zero register.
    cyc(1'b1, LD, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0);
    check("r0_zero_reg", oaz, 16'h0000);
    check("r0_zero_reg_b", obz, 16'h0000);
    check("r0_normal", oa1, 16'hFFFF);
    cyc(1'b1, INC, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0);
    check("r0_inc_no_wrap_z", {15'd0, wrapz}, 16'h0000);
    check("r0_inc_wrap_normal", {15'd0, wrap1}, 16'h0001);
    check("r0_bypass_z", oaz, 16'h0000);
    cyc(1'b0, LD, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0);
    check("r0_after_inc", oa1, 16'h0000);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
